// File: rtl/dma_cmd_issuer.sv
// dma_cmd_issuer: splits one DMA descriptor into AXI-legal commands and issues them.
//
// Each command is capped at MAX_CHUNK_BYTES. INCR commands never cross a 4 KB page.
// A command the engine aborts is reissued unchanged after RETRY_GAP idle cycles. The
// descriptor fails once a single command has been aborted more than MAX_RETRY times.
//
// Ports:
//   AXI_ACLK, AXI_ARESET      clock, synchronous active-high reset
//   desc_*                    descriptor input; desc_ready is high only when idle
//   cmd_*                     command output with a valid/ready/abort handshake
//   busy                      a descriptor is in progress
//   done / err                one-cycle completion pulses
//   err_code                  1 = bad descriptor, 2 = retries exhausted; held until next accept
//   chunk_cnt                 number of commands accepted for the current descriptor
module dma_cmd_issuer #(
    parameter int unsigned AXI_ID_WD       = 2,
    parameter int unsigned AXI_ADDR_WD     = 32,
    parameter int unsigned AXI_STRB_WD     = 4,
    parameter int unsigned MAX_CHUNK_BYTES = 1024,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned RETRY_GAP       = 4
) (
    input  logic                   AXI_ACLK,
    input  logic                   AXI_ARESET,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [AXI_ADDR_WD-1:0] desc_addr,
    input  logic [AXI_ADDR_WD-1:0] desc_len,
    input  logic [AXI_ID_WD-1:0]   desc_id,
    input  logic [1:0]             desc_burst,
    input  logic [2:0]             desc_size,
    output logic                   cmd_valid,
    output logic [AXI_ADDR_WD-1:0] cmd_addr,
    output logic [AXI_ID_WD-1:0]   cmd_id,
    output logic [1:0]             cmd_burst,
    output logic [2:0]             cmd_size,
    output logic [AXI_ADDR_WD-1:0] cmd_len,
    input  logic                   cmd_ready,
    input  logic                   cmd_abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [15:0]            chunk_cnt
);

    localparam int unsigned MaxSize = $clog2(AXI_STRB_WD);
    localparam int unsigned RetryWd = $clog2(MAX_RETRY + 2);
    localparam int unsigned GapWd   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [AXI_ADDR_WD-1:0] MaxChunk  = AXI_ADDR_WD'(MAX_CHUNK_BYTES);
    localparam logic [AXI_ADDR_WD-1:0] PageBytes = AXI_ADDR_WD'(4096);
    localparam logic [1:0]             BurstIncr = 2'd1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCalc,
        StIssue,
        StBackoff,
        StFin
    } state_e;

    state_e                 state_q, state_d;
    logic [AXI_ADDR_WD-1:0] addr_q, addr_d;
    logic [AXI_ADDR_WD-1:0] rem_q, rem_d;
    logic [AXI_ID_WD-1:0]   id_q, id_d;
    logic [1:0]             burst_q, burst_d;
    logic [2:0]             size_q, size_d;
    logic [AXI_ADDR_WD-1:0] cmd_addr_q, cmd_addr_d;
    logic [AXI_ADDR_WD-1:0] cmd_len_q, cmd_len_d;
    logic [RetryWd-1:0]     retry_q, retry_d;
    logic [GapWd-1:0]       gap_q, gap_d;
    logic [15:0]            chunk_cnt_q, chunk_cnt_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   fin_err_q, fin_err_d;

    logic [AXI_ADDR_WD-1:0] size_mask;
    logic [AXI_ADDR_WD-1:0] to_page;
    logic [AXI_ADDR_WD-1:0] chunk;
    logic                   bad_desc;

    // Descriptor legality and chunk sizing, both from the latched descriptor state.
    always_comb begin
        size_mask = (AXI_ADDR_WD'(1) << size_q) - AXI_ADDR_WD'(1);
        bad_desc  = (rem_q == '0) || (burst_q > BurstIncr) || (size_q > 3'(MaxSize)) ||
                    ((addr_q & size_mask) != '0) || ((rem_q & size_mask) != '0);

        to_page = PageBytes - AXI_ADDR_WD'(addr_q[11:0]);
        chunk   = rem_q;
        if (chunk > MaxChunk) begin
            chunk = MaxChunk;
        end
        // FIXED bursts hit one address, so page crossing does not apply.
        if ((burst_q == BurstIncr) && (chunk > to_page)) begin
            chunk = to_page;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        id_d        = id_q;
        burst_d     = burst_q;
        size_d      = size_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        chunk_cnt_d = chunk_cnt_q;
        err_code_d  = err_code_q;
        fin_err_d   = fin_err_q;

        unique case (state_q)
            StIdle: begin
                if (desc_valid) begin
                    addr_d      = desc_addr;
                    rem_d       = desc_len;
                    id_d        = desc_id;
                    burst_d     = desc_burst;
                    size_d      = desc_size;
                    err_code_d  = 2'd0;
                    chunk_cnt_d = 16'd0;
                    fin_err_d   = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (bad_desc) begin
                    err_code_d = 2'd1;
                    fin_err_d  = 1'b1;
                    state_d    = StFin;
                end else begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cmd_addr_d = addr_q;
                cmd_len_d  = chunk;
                retry_d    = '0;
                state_d    = StIssue;
            end
            StIssue: begin
                // Abort wins over ready in the same cycle.
                if (cmd_abort) begin
                    retry_d = retry_q + RetryWd'(1);
                    if (retry_d > RetryWd'(MAX_RETRY)) begin
                        err_code_d = 2'd2;
                        fin_err_d  = 1'b1;
                        state_d    = StFin;
                    end else if (RETRY_GAP == 0) begin
                        state_d = StIssue;
                    end else begin
                        gap_d   = '0;
                        state_d = StBackoff;
                    end
                end else if (cmd_ready) begin
                    if (chunk_cnt_q != 16'hFFFF) begin
                        chunk_cnt_d = chunk_cnt_q + 16'd1;
                    end
                    rem_d = rem_q - cmd_len_q;
                    if (burst_q == BurstIncr) begin
                        addr_d = addr_q + cmd_len_q;
                    end
                    if (rem_d == '0) begin
                        fin_err_d = 1'b0;
                        state_d   = StFin;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StBackoff: begin
                if (gap_q == GapWd'(RETRY_GAP - 1)) begin
                    state_d = StIssue;
                end else begin
                    gap_d = gap_q + GapWd'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            id_q        <= '0;
            burst_q     <= '0;
            size_q      <= '0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            chunk_cnt_q <= '0;
            err_code_q  <= '0;
            fin_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            id_q        <= id_d;
            burst_q     <= burst_d;
            size_q      <= size_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            chunk_cnt_q <= chunk_cnt_d;
            err_code_q  <= err_code_d;
            fin_err_q   <= fin_err_d;
        end
    end

    assign desc_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign cmd_valid  = (state_q == StIssue);
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign cmd_id     = id_q;
    assign cmd_burst  = burst_q;
    assign cmd_size   = size_q;
    assign done       = (state_q == StFin) && !fin_err_q;
    assign err        = (state_q == StFin) && fin_err_q;
    assign err_code   = err_code_q;
    assign chunk_cnt  = chunk_cnt_q;

endmodule

// File: doc/dma_cmd_issuer.md
Name: dma_cmd_issuer

Overview:
- Command-side initiator for the AXI master read/write engines: the producer of the cmd_valid/cmd_addr/cmd_id/cmd_burst/cmd_size/cmd_len interface that the masters consume.
- Accepts one DMA descriptor (start address, total byte length, ID, burst type, beat size).
- Splits the descriptor into legal commands: each command is capped at a maximum chunk size and never crosses a 4 KB boundary.
- Issues the commands with a valid/ready handshake and retries any command the engine aborts, up to a retry limit.

Parameters:
AXI_ID_WD, 2, command ID width
AXI_ADDR_WD, 32, address and length width
AXI_STRB_WD, 4, data bus bytes; legal cmd_size is at most log2(AXI_STRB_WD)
MAX_CHUNK_BYTES, 1024, maximum bytes per command; power of two, at most 4096, at least AXI_STRB_WD
MAX_RETRY, 3, aborts tolerated per command before error
RETRY_GAP, 4, idle cycles between an abort and the reissue

Ports:
AXI_ACLK  in  1  clock
AXI_ARESET  in  1  synchronous active-high reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  high only in IDLE
desc_addr  in  AXI_ADDR_WD  start byte address
desc_len  in  AXI_ADDR_WD  total bytes; 0 is illegal
desc_id  in  AXI_ID_WD  ID copied to every command
desc_burst  in  2  0=FIXED, 1=INCR, 2/3 illegal
desc_size  in  3  log2 bytes per beat
cmd_valid  out  1  command valid
cmd_addr  out  AXI_ADDR_WD  chunk start address
cmd_id  out  AXI_ID_WD  command ID
cmd_burst  out  2  command burst type
cmd_size  out  3  command beat size
cmd_len  out  AXI_ADDR_WD  chunk bytes
cmd_ready  in  1  engine accepts command
cmd_abort  in  1  engine rejects current command
busy  out  1  descriptor in progress
done  out  1  one-cycle pulse on success
err  out  1  one-cycle pulse on failure
err_code  out  2  1=bad descriptor, 2=retry exhausted; held until next descriptor accepted
chunk_cnt  out  16  commands accepted for current descriptor

Behaviour:
- Reset: state IDLE, desc_ready=1, all other outputs 0.
- Reset mid-operation abandons the current descriptor; no done or err is issued.
- States: IDLE, CHECK, CALC, ISSUE, BACKOFF, FIN.
- IDLE: desc_valid & desc_ready latches the descriptor and clears err_code and chunk_cnt; next state CHECK. busy=1 in every state except IDLE.
- CHECK (1 cycle): the descriptor is bad if any of the following holds:
  - desc_len==0
  - desc_burst>1
  - desc_size>log2(AXI_STRB_WD)
  - desc_addr not aligned to 1<<desc_size
  - desc_len not a multiple of 1<<desc_size
- CHECK outcome: bad goes to FIN with err=1 and err_code=1, and no command is issued; good goes to CALC.
- CALC (1 cycle), chunk size:
  - INCR: min(remaining, MAX_CHUNK_BYTES, 4096 - addr[11:0]).
  - FIXED: min(remaining, MAX_CHUNK_BYTES); no 4 KB split.
  - Result is registered into cmd_len and cmd_addr; retry counter cleared; next state ISSUE.
- ISSUE:
  - cmd_valid=1; all cmd_* outputs stable until the handshake.
  - cmd_abort=1 has priority over cmd_ready in the same cycle.
  - Abort: cmd_valid drops next cycle and the retry counter increments. If the count is now greater than MAX_RETRY, go to FIN with err_code=2. Otherwise go to BACKOFF.
  - cmd_ready=1 without abort: chunk_cnt increments and remaining decreases by cmd_len. For INCR, addr increases by cmd_len; for FIXED, addr is unchanged. If remaining reaches 0, go to FIN with done; otherwise go to CALC.
- BACKOFF: exactly RETRY_GAP cycles with cmd_valid=0, then ISSUE with identical cmd_* values.
- FIN (1 cycle): pulses done or err, never both; next state IDLE.
- Latency:
  - A good descriptor asserts cmd_valid 3 cycles after the accepting edge (CHECK, CALC, ISSUE).
  - Back-to-back chunks have 1 idle cycle between them (CALC).
- Arithmetic:
  - Remaining is AXI_ADDR_WD wide.
  - Address addition wraps modulo 2^AXI_ADDR_WD.
  - chunk_cnt saturates at 16'hFFFF.
- Descriptors offered while busy are not accepted (desc_ready=0).

Test Plan:
- INCR, addr 0x0000_0F00, len 0x400, size 2, ready always high -> 2 commands: (0xF00, 0x100) then (0x1000, 0x300); done pulse; chunk_cnt=2; first cmd_valid 3 cycles after accept.
- INCR, addr 0x2000, len 0xA00, MAX_CHUNK_BYTES 1024 -> commands (0x2000, 0x400), (0x2400, 0x400), (0x2800, 0x200); cmd_ready held low 5 cycles on the 2nd command -> cmd_* stable throughout.
- FIXED, addr 0x100, len 0x800 -> 2 commands, both addr 0x100, len 0x400, burst 0.
- Abort on first command twice, then ready -> cmd_valid low for exactly 4 cycles between tries, same addr/len reissued, done pulse; abort 4 times -> err pulse, err_code=2, no further cmd_valid.
- Bad descriptors (len 0; addr 0x102 with size 2; burst 2; size 3 on a 4-byte bus) -> err pulse, err_code=1, cmd_valid never asserted, back in IDLE after FIN.
- Reset asserted during ISSUE -> next cycle cmd_valid=0, busy=0, desc_ready=1, no done or err pulse.
